// File: rtl/cpu_sdr_bridge.sv
// rtl/cpu_sdr_bridge.sv - V30 bus to single SDRAM port bridge, toggle req/ack handshake
// Optional posted writes to writable regions: define BRIDGE_WRITE_POST_EN.
module cpu_sdr_bridge #(
  parameter int NUM_REGIONS  = 4,
  parameter int REGION_SEL_W = 2,
  parameter int OFFSET_W     = 16,
  parameter int ADDR_W       = 20,
  parameter int SDR_AW       = 24
) (
  input  logic                   CLK_32M,
  input  logic                   reset_n,
  input  logic [ADDR_W-1:0]      cpu_addr,
  input  logic [15:0]            cpu_din,
  input  logic [1:0]             cpu_be,
  input  logic                   cpu_rd,
  input  logic                   cpu_wr,
  input  logic                   pause,
  input  logic [NUM_REGIONS-1:0] region_hit,
  input  logic [NUM_REGIONS-1:0] region_wren,
  output logic [15:0]            cpu_dout,
  output logic                   busy,
  output logic                   miss,
  output logic [SDR_AW-1:0]      sdr_addr,
  output logic [15:0]            sdr_din,
  output logic [1:0]             sdr_wr_sel,
  output logic                   sdr_req,
  input  logic                   sdr_ack,
  input  logic [15:0]            sdr_dout
);

  localparam int PAD_W = SDR_AW - REGION_SEL_W - OFFSET_W;

  typedef enum logic [1:0] {SYNC, IDLE, PAUSED, REQ} state_t;

  state_t                  state_q;
  logic                    acc_prev_q, pend_q, odd_q, rd_q, posted_q;
  logic                    cpu_acc, any_hit, start_hit, start_miss, wr_ok, posted_d, do_issue;
  logic [REGION_SEL_W-1:0] idx;
  logic [SDR_AW-1:0]       addr_d;
  logic [15:0]             din_d;
  logic [1:0]              sel_d;
  logic                    addr_hi_unused;

  assign addr_hi_unused = ^cpu_addr[ADDR_W-1:OFFSET_W+1];

  // Lowest set hit bit wins when the PALs overlap.
  always_comb begin
    idx = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--)
      if (region_hit[i]) idx = REGION_SEL_W'(i);
  end

  assign cpu_acc    = cpu_rd | cpu_wr;
  assign any_hit    = |region_hit;
  assign start_hit  = cpu_acc & ~acc_prev_q & any_hit;
  assign start_miss = cpu_acc & ~acc_prev_q & ~any_hit;
  assign wr_ok      = cpu_wr & region_wren[idx];
  assign addr_d     = {{PAD_W{1'b0}}, idx, cpu_addr[OFFSET_W:1]};
  assign din_d      = cpu_addr[0] ? {cpu_din[7:0], 8'h00} : cpu_din;
  assign sel_d      = !wr_ok ? 2'b00 : (cpu_addr[0] ? {cpu_be[0], 1'b0} : cpu_be);

`ifdef BRIDGE_WRITE_POST_EN
  assign posted_d = wr_ok;
`else
  assign posted_d = 1'b0;
`endif

  assign do_issue = ((state_q == IDLE) && (sdr_ack == sdr_req) && (start_hit || pend_q)
                     && any_hit && !pause)
                  || ((state_q == PAUSED) && !pause);

  assign busy = start_hit | pend_q | (state_q == PAUSED) | ((state_q == REQ) && !posted_q);

  always_ff @(posedge CLK_32M or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= SYNC;
      acc_prev_q <= 1'b0;
      pend_q     <= 1'b0;
      odd_q      <= 1'b0;
      rd_q       <= 1'b0;
      posted_q   <= 1'b0;
      cpu_dout   <= 16'h0000;
      miss       <= 1'b0;
      sdr_addr   <= '0;
      sdr_din    <= 16'h0000;
      sdr_wr_sel <= 2'b00;
      sdr_req    <= 1'b0;
    end else begin
      acc_prev_q <= cpu_acc;
      miss       <= start_miss;
      if (start_miss) cpu_dout <= 16'hFFFF;

      case (state_q)
        SYNC: begin
          if (start_hit) pend_q <= 1'b1;
          if (sdr_ack == sdr_req) state_q <= IDLE;
        end
        IDLE: begin
          // A stray ack toggle (e.g. after our reset) is re-absorbed in SYNC.
          if (sdr_ack != sdr_req) begin
            state_q <= SYNC;
            if (start_hit) pend_q <= 1'b1;
          end else if ((start_hit || pend_q) && pause) begin
            state_q <= PAUSED;
            pend_q  <= 1'b0;
          end
        end
        PAUSED: begin
          if (start_hit) pend_q <= 1'b1;
        end
        REQ: begin
          if (start_hit) pend_q <= 1'b1;
          if (sdr_ack == sdr_req) begin
            state_q <= IDLE;
            if (rd_q) cpu_dout <= odd_q ? {8'h00, sdr_dout[15:8]} : sdr_dout;
          end
        end
        default: state_q <= SYNC;
      endcase

      if (do_issue) begin
        state_q    <= REQ;
        sdr_req    <= ~sdr_ack;
        sdr_addr   <= addr_d;
        sdr_din    <= din_d;
        sdr_wr_sel <= sel_d;
        odd_q      <= cpu_addr[0];
        rd_q       <= ~cpu_wr;
        posted_q   <= posted_d;
        pend_q     <= (state_q == PAUSED) && start_hit;
      end
    end
  end

endmodule

// File: tb/tb_cpu_sdr_bridge.sv
// tb/tb_cpu_sdr_bridge.sv - directed self-checking bench for cpu_sdr_bridge
module tb_cpu_sdr_bridge;

  logic        CLK_32M = 1'b0;
  logic        reset_n = 1'b0;
  logic [19:0] cpu_addr = '0;
  logic [15:0] cpu_din = '0;
  logic [1:0]  cpu_be = '0;
  logic        cpu_rd = 1'b0;
  logic        cpu_wr = 1'b0;
  logic        pause = 1'b0;
  logic [3:0]  region_hit = '0;
  logic [3:0]  region_wren = 4'b0110;
  logic [15:0] cpu_dout;
  logic        busy, miss;
  logic [23:0] sdr_addr;
  logic [15:0] sdr_din;
  logic [1:0]  sdr_wr_sel;
  logic        sdr_req;
  logic        sdr_ack = 1'b0;
  logic [15:0] sdr_dout = '0;

  int total = 0;
  int bad = 0;

  cpu_sdr_bridge dut (
    .CLK_32M(CLK_32M), .reset_n(reset_n), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_be(cpu_be), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .pause(pause),
    .region_hit(region_hit), .region_wren(region_wren), .cpu_dout(cpu_dout),
    .busy(busy), .miss(miss), .sdr_addr(sdr_addr), .sdr_din(sdr_din),
    .sdr_wr_sel(sdr_wr_sel), .sdr_req(sdr_req), .sdr_ack(sdr_ack), .sdr_dout(sdr_dout)
  );

  always #15 CLK_32M = ~CLK_32M;

  // SDRAM controller stand-in: acks ack_dly negedges after seeing a new toggle.
  logic        ctl_en = 1'b1;
  int          ack_dly = 2;
  int          wait_cnt = 0;
  logic [15:0] rd_data = '0;
  logic        req_last = 1'b0;
  int          toggles = 0;
  int          flip_req = 0;
  int          flip_done = 0;
  logic [23:0] cap_addr = '0;
  logic [1:0]  cap_sel = '0;
  logic [15:0] cap_din = '0;

  always @(negedge CLK_32M) begin
    if (sdr_req !== req_last) begin
      toggles++;
      req_last = sdr_req;
      cap_addr = sdr_addr;
      cap_sel  = sdr_wr_sel;
      cap_din  = sdr_din;
    end
    if (flip_req != flip_done) begin
      sdr_ack   = ~sdr_ack;
      flip_done = flip_req;
    end
    if (ctl_en && (sdr_req !== sdr_ack)) begin
      if (wait_cnt >= ack_dly) begin
        sdr_ack  = sdr_req;
        sdr_dout = rd_data;
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drives one CPU access and returns how many samples busy was high.
  task automatic do_acc(input logic [19:0] a, input logic rd, input logic wr,
                        input logic [15:0] din, input logic [1:0] be,
                        input logic [3:0] hit, output int nb);
    @(negedge CLK_32M);
    cpu_addr = a; cpu_din = din; cpu_be = be; region_hit = hit;
    cpu_rd = rd; cpu_wr = wr;
    #1;
    nb = 0;
    for (int k = 0; k < 300 && busy; k++) begin
      nb++;
      @(negedge CLK_32M);
      #1;
    end
    cpu_rd = 1'b0; cpu_wr = 1'b0;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, t0;

    repeat (3) @(negedge CLK_32M);
    check_eq("rst_dout", cpu_dout, 16'h0000);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_miss", miss, 1'b0);
    check_eq("rst_req", sdr_req, 1'b0);
    check_eq("rst_sel", sdr_wr_sel, 2'b00);
    check_eq("rst_addr", sdr_addr, 24'h0);
    reset_n = 1'b1;
    repeat (3) @(negedge CLK_32M);

    // Even read, region 1
    t0 = toggles; ack_dly = 5; rd_data = 16'hBEEF;
    do_acc(20'h04002, 1'b1, 1'b0, 16'h0, 2'b11, 4'b0010, nb);
    check_eq("rd_busy", nb, 7);
    check_eq("rd_addr", cap_addr, 24'h012001);
    check_eq("rd_sel", cap_sel, 2'b00);
    check_eq("rd_dout", cpu_dout, 16'hBEEF);
    check_eq("rd_tog", toggles, t0 + 1);

    // Odd write to writable region 2
    ack_dly = 2; rd_data = 16'h1111;
    do_acc(20'h00005, 1'b0, 1'b1, 16'h0012, 2'b01, 4'b0100, nb);
`ifdef BRIDGE_WRITE_POST_EN
    check_eq("wr_busy", nb, 1);
`else
    check_eq("wr_busy", nb, 4);
`endif
    check_eq("wr_din", cap_din, 16'h1200);
    check_eq("wr_sel", cap_sel, 2'b10);
    check_eq("wr_addr", cap_addr, 24'h020002);
    check_eq("wr_dout", cpu_dout, 16'hBEEF);
    repeat (6) @(negedge CLK_32M);

    // Write to read-only region 0
    t0 = toggles; rd_data = 16'h1234;
    do_acc(20'h00010, 1'b0, 1'b1, 16'h5555, 2'b11, 4'b0001, nb);
    check_eq("ro_busy", nb, 4);
    check_eq("ro_sel", cap_sel, 2'b00);
    check_eq("ro_tog", toggles, t0 + 1);
    check_eq("ro_dout", cpu_dout, 16'hBEEF);

    // Odd read, overlapping hits 1 and 3 -> region 1
    rd_data = 16'hA55A;
    do_acc(20'h04003, 1'b1, 1'b0, 16'h0, 2'b11, 4'b1010, nb);
    check_eq("odd_addr", cap_addr, 24'h012001);
    check_eq("odd_dout", cpu_dout, 16'h00A5);

    // No region hit
    t0 = toggles;
    @(negedge CLK_32M);
    cpu_addr = 20'h00400; region_hit = 4'b0000; cpu_rd = 1'b1;
    #1 check_eq("miss_busy0", busy, 1'b0);
    @(negedge CLK_32M); #1;
    check_eq("miss_pulse", miss, 1'b1);
    check_eq("miss_busy1", busy, 1'b0);
    @(negedge CLK_32M); #1;
    check_eq("miss_end", miss, 1'b0);
    check_eq("miss_dout", cpu_dout, 16'hFFFF);
    check_eq("miss_tog", toggles, t0);
    cpu_rd = 1'b0;
    repeat (2) @(negedge CLK_32M);

    // Pause held for 20 cycles at the access edge
    @(negedge CLK_32M);
    t0 = toggles; rd_data = 16'h0F0F;
    pause = 1'b1; cpu_addr = 20'h00300; region_hit = 4'b1000; cpu_rd = 1'b1;
    nb = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK_32M); #1;
      if (busy) nb++;
    end
    check_eq("pause_busy", nb, 20);
    check_eq("pause_tog", toggles, t0);
    pause = 1'b0;
    @(negedge CLK_32M); #1;
    check_eq("pause_rel_tog", toggles, t0 + 1);
    for (int k = 0; k < 50 && busy; k++) begin
      @(negedge CLK_32M); #1;
    end
    check_eq("pause_done", busy, 1'b0);
    check_eq("pause_addr", cap_addr, 24'h030180);
    check_eq("pause_dout", cpu_dout, 16'h0F0F);
    cpu_rd = 1'b0;

    // Simultaneous read and write edges act as a write
    do_acc(20'h00020, 1'b1, 1'b1, 16'hABCD, 2'b11, 4'b0010, nb);
    check_eq("rw_sel", cap_sel, 2'b11);
    check_eq("rw_din", cap_din, 16'hABCD);
    check_eq("rw_addr", cap_addr, 24'h010010);
    check_eq("rw_dout", cpu_dout, 16'h0F0F);
    repeat (8) @(negedge CLK_32M);

    // Reset in the middle of an outstanding request
    ctl_en = 1'b0;
    @(negedge CLK_32M);
    cpu_addr = 20'h00100; region_hit = 4'b0010; cpu_rd = 1'b1;
    repeat (3) @(negedge CLK_32M);
    #1 reset_n = 1'b0; cpu_rd = 1'b0;
    #1;
    check_eq("mid_rst_req", sdr_req, 1'b0);
    check_eq("mid_rst_busy", busy, 1'b0);
    check_eq("mid_rst_dout", cpu_dout, 16'h0000);
    check_eq("mid_rst_sel", sdr_wr_sel, 2'b00);
    @(negedge CLK_32M);
    reset_n = 1'b1;
    repeat (2) @(negedge CLK_32M);
    t0 = toggles; nb = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK_32M); #1;
      if (k == 4) flip_req++;
      if (busy) nb++;
    end
    check_eq("late_ack_busy", nb, 0);
    check_eq("late_ack_tog", toggles, t0);
    check_eq("late_ack_dout", cpu_dout, 16'h0000);
    ctl_en = 1'b1;
    repeat (10) @(negedge CLK_32M);
    ack_dly = 2; rd_data = 16'h3C3C;
    do_acc(20'h00200, 1'b1, 1'b0, 16'h0, 2'b11, 4'b0010, nb);
    check_eq("post_rst_busy", nb, 4);
    check_eq("post_rst_addr", cap_addr, 24'h010100);
    check_eq("post_rst_dout", cpu_dout, 16'h3C3C);

    // Write immediately followed by a read
    repeat (3) @(negedge CLK_32M);
    t0 = toggles; ack_dly = 3; rd_data = 16'h9696;
    do_acc(20'h00040, 1'b0, 1'b1, 16'h7777, 2'b11, 4'b0100, nb);
`ifdef BRIDGE_WRITE_POST_EN
    check_eq("b2b_wr_busy", nb, 1);
`else
    check_eq("b2b_wr_busy", nb, 5);
`endif
    do_acc(20'h04004, 1'b1, 1'b0, 16'h0, 2'b11, 4'b0010, nb);
`ifdef BRIDGE_WRITE_POST_EN
    check_eq("b2b_rd_busy", nb, 8);
`else
    check_eq("b2b_rd_busy", nb, 5);
`endif
    check_eq("b2b_tog", toggles, t0 + 2);
    check_eq("b2b_addr", cap_addr, 24'h012002);
    check_eq("b2b_dout", cpu_dout, 16'h9696);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
